fifo_param: RTL
===============

# fifo_param

Parametrised synchronous FIFO that succeeds the fixed-size FIFO block. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, a live occupancy count, and a first-word-fall-through (FWFT) read mode. It also accepts a write while full when a read happens in the same cycle. It sits between a single-clock producer and consumer and keeps the existing handshake/status signal set, so current benches can be retargeted.

## Interface
- DATA_WIDTH, 16, word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-1, almostfull asserts when count ≥ AF_THRESH (1 ≤ AF_THRESH < DEPTH)
- AE_THRESH, 1, almostempty asserts when count ≤ AE_THRESH (0 < AE_THRESH < DEPTH)
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- wr_ack  out  1  registered pulse: the previous cycle's write was accepted
- overflow  out  1  registered pulse: the previous cycle's write was rejected
- underflow  out  1  registered pulse: the previous cycle's read was rejected
- full / empty  out  1  combinational from count: count==DEPTH / count==0
- almostfull  out  1  count ≥ AF_THRESH && count < DEPTH
- almostempty  out  1  count ≤ AE_THRESH && count > 0
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Definitions: wr_ok = wr_en && (!full || rd_en); rd_ok = rd_en && !empty.
- Write: on wr_ok, mem[wr_ptr] ← data_in and wr_ptr increments mod DEPTH.
- Read: on rd_ok, rd_ptr increments mod DEPTH.
- Count update: +1 if wr_ok only, −1 if rd_ok only, unchanged if both or neither.
- Full with wr_en && rd_en: both operations succeed. count stays DEPTH, wr_ack=1, overflow=0.
- Empty with wr_en && rd_en: only the write succeeds, and underflow=1. In FWFT mode the written word appears on data_out the next cycle.
- Pulse outputs (each set on the next edge):
  - wr_ack = wr_ok
  - overflow = wr_en && !wr_ok
  - underflow = rd_en && !rd_ok
- Registered-read mode (FWFT=0): on rd_ok, data_out ← mem[rd_ptr] at the same edge. Otherwise data_out holds its value.
- FWFT mode (FWFT=1): data_out = empty ? '0 : mem[rd_ptr], combinationally. rd_ok consumes the displayed word.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are resolved from count, not from pointer comparison.
- Reset (async assert, any time, including mid-transfer):
  - wr_ptr, rd_ptr, count ← 0
  - wr_ack, overflow, underflow ← 0
  - data_out ← 0
  - hence empty=1, full=0, almostfull=0, almostempty=0
  - memory contents are not cleared
- Reset is released synchronously by the environment (deassert away from posedge). The first accepted operation is on the first posedge with rst_n=1.

## Timing
- Write-to-visible latency:
  - FWFT=0: a word written at edge N can be read at edge N+1; data_out is valid after that edge.
  - FWFT=1: the word is on data_out right after edge N when the FIFO was empty.
- count and all level flags change only on posedge (or async reset). They are valid for the whole following cycle.
- wr_ack, overflow and underflow are high for exactly one cycle per qualifying request. Back-to-back requests give continuous high.
- No combinational path from wr_en/rd_en to any output, except through count at the next edge.

## Structure
- Shared package fifo_pkg holds:
  - default constants FIFO_DATA_WIDTH=16 and FIFO_DEPTH=8
  - a function fifo_cnt_w(depth) returning $clog2(depth+1)
  - the transaction class fields reused by the bench
- One sub-module, fifo_mem: a DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port addressed by rd_ptr, no reset.
- fifo_param holds pointers, count, handshake registers, flag decode and the FWFT output mux.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=16, AF_THRESH=6, AE_THRESH=2.
- Fill, then drain:
  - 8 writes of 0x0001..0x0008 → count 1..8; almostfull from count 6; full at 8; wr_ack high 8 cycles.
  - Then 8 reads, FWFT=0 → data_out 0x0001..0x0008 one edge after each rd_en; empty at the end; almostempty at counts 2 and 1.
- Overflow and full+read:
  - At full, wr_en only → overflow pulse, count stays 8, data unchanged.
  - At full, wr_en+rd_en with 0xAAAA → wr_ack=1, overflow=0, count 8; 0xAAAA is read out 8 reads later.
- Underflow and empty+write: at empty, rd_en only → underflow pulse, data_out unchanged. wr_en+rd_en with 0x1234 → underflow=1, wr_ack=1, count 1.
- FWFT=1: write 0x00BE while empty → data_out=0x00BE on the next cycle with no rd_en. The next rd_en pops it, and data_out shows 0 once the FIFO is empty.
- Wrap-around: 5 writes, 5 reads, then 8 writes and 8 reads (pointers wrap) → data order preserved and count returns to 0.
- Mid-operation reset: at count 5, assert rst_n=0 between edges → empty=1, count=0, data_out=0 and pulses 0 immediately. After release, a single write then read returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, count-width helper and transaction record for
// the parametrised FIFO and the environments that drive it.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_DEPTH      = 8;

  // Occupancy needs to represent 0..depth inclusive, hence depth+1.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One cycle of producer/consumer activity.
  typedef struct packed {
    logic                       wr;
    logic                       rd;
    logic [FIFO_DATA_WIDTH-1:0] data;
  } fifo_txn_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage array, no reset.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe, stores wr_data at wr_addr on posedge
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - asynchronous read address
//   rd_data  - mem[rd_addr], combinational
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and optional FWFT output.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   data_in, wr_en    - write side
//   rd_en, data_out   - read side (registered or fall-through per FWFT)
//   wr_ack            - pulse: previous cycle's write accepted
//   overflow          - pulse: previous cycle's write rejected
//   underflow         - pulse: previous cycle's read rejected
//   full, empty       - count==DEPTH / count==0
//   almostfull        - AF_THRESH <= count < DEPTH
//   almostempty       - 0 < count <= AE_THRESH
//   count             - current occupancy
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL  = CW'(AE_THRESH);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  wr_ok, rd_ok;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  assign almostfull  = (count >= AF_LVL) && !full;
  assign almostempty = (count <= AE_LVL) && !empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_ok && !rd_ok)      count <= count + CNT_ONE;
      else if (rd_ok && !wr_ok) count <= count - CNT_ONE;
      wr_ack    <= wr_ok;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && !rd_ok;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; a read simply advances past it.
      assign data_out = empty ? '0 : mem_rd;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_q <= '0;
        else if (rd_ok) data_q <= mem_rd;
      end
      assign data_out = data_q;
    end
  endgenerate

endmodule
